fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port stall  input  1  hold request from downstream; 1 freezes the stage.
REQ-004 SHALL have port jflag  input  1  jump-taken flag from the jump-calculation stage, derived from instr_out/pc_out.
REQ-005 SHALL have port jdest  input  12  jump target address from the jump-calculation stage.
REQ-006 SHALL have port imem_addr  output  12  instruction memory address, equal to fetch PC register fpc.
REQ-007 SHALL have port imem_en  output  1  instruction memory read enable.
REQ-008 SHALL have port imem_rdata  input  16  memory word; synchronous read, valid the cycle after an enabled address; held while imem_en=0.
REQ-009 SHALL have port instr_out  output  16  current instruction, driven directly from imem_rdata.
REQ-010 SHALL have port pc_out  output  12  address of instr_out (registered).
REQ-011 SHALL have port valid_out  output  1  instr_out/pc_out hold a live instruction.
REQ-012 SHALL have port halted  output  1  HLT executed; fetch stopped.

Function
REQ-013 SHALL implement states RUN, BUBBLE, HALT; imem_en = !stall && state!=HALT.
REQ-014 RUN, stall=0, no redirect, no HLT: fpc<=fpc+1 (12-bit wrap 4095->0), pc_out<=fpc, valid_out<=1.
REQ-015 Redirect SHALL occur when state=RUN, valid_out=1, stall=0, jflag=1: fpc<=jdest, valid_out<=0, state<=BUBBLE.
REQ-016 BUBBLE, stall=0: fetch at fpc (jdest) is issued, fpc<=fpc+1, pc_out<=fpc, valid_out<=1, state<=RUN; taken-jump penalty is exactly one bubble cycle.
REQ-017 jflag SHALL be ignored whenever valid_out=0 or stall=1 or state!=RUN.
REQ-018 HLT SHALL be instr_out[15:14]=2'b11 and instr_out[7:4]=4'b1111; when valid_out=1, stall=0, state=RUN: state<=HALT, valid_out<=0, halted<=1, fpc unchanged.
REQ-019 HLT SHALL take priority over jflag if both are presented in the same cycle.
REQ-020 HALT SHALL be exited only by reset; imem_en=0, valid_out=0, halted=1 throughout.
REQ-021 stall=1 SHALL hold fpc, pc_out, valid_out, state, halted unchanged; imem_en=0 keeps instr_out stable.
REQ-022 Stall deassertion SHALL resume with the identical instr_out/pc_out presented before the stall; no instruction lost or duplicated.
REQ-023 jdest SHALL be loaded unmodified (no +1 applied in this stage).

Reset
REQ-024 rst_n=0 SHALL immediately force fpc=0, pc_out=0, valid_out=0, halted=0, state=RUN, regardless of clock or operation in progress.
REQ-025 First edge after rst_n rises SHALL issue fetch of address 0; valid_out=1 with pc_out=0 one cycle later.
REQ-026 Reset asserted during BUBBLE, HALT, or stall SHALL discard the pending redirect, halt, or hold.

Verification
REQ-027 Release reset, mem[n]=n-indexed non-jump words, stall=0 -> pc_out 0,1,2,3 on consecutive cycles, valid_out=1 from cycle 1.
REQ-028 jflag=1, jdest=0x040 while pc_out=0x005 valid -> next cycle valid_out=0, following cycle pc_out=0x040, valid_out=1.
REQ-029 stall=1 for 3 cycles at pc_out=0x010 -> pc_out, instr_out, valid_out unchanged, imem_en=0; after release pc_out=0x011 next cycle.
REQ-030 instr_out=16'hC0F0 valid -> next cycle halted=1, valid_out=0, imem_en=0; jflag=1 in the same cycle ignored; state persists until reset.
REQ-031 fpc=0xFFF sequential -> pc_out 0xFFF then 0x000.
REQ-032 jflag=1 while valid_out=0 (bubble) or stall=1 -> no redirect, fpc unchanged.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage for a 12-bit address / 16-bit instruction machine.
// Feeds a synchronous-read instruction memory, presents the returned word
// together with its address, redirects on taken jumps with a single bubble,
// and stops permanently (until reset) once an HLT instruction is presented.
module fetch_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jflag,
    input  logic [11:0] jdest,
    output logic [11:0] imem_addr,
    output logic        imem_en,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr_out,
    output logic [11:0] pc_out,
    output logic        valid_out,
    output logic        halted
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] BUBBLE = 2'd1;
    localparam logic [1:0] HALT   = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [11:0] fpc;
    logic [11:0] fpc_next;
    logic [11:0] pc_next;
    logic        valid_next;
    logic        halted_next;
    logic        is_hlt;
    logic        live_run;

    // The memory word is the instruction; its address is the registered pc_out.
    // Holding imem_en low keeps the memory output, and thus instr_out, stable.
    assign instr_out = imem_rdata;
    assign imem_addr = fpc;
    assign imem_en   = !stall && (state != HALT);

    // HLT is recognised from the opcode class and the function field together,
    // and only acts while a live instruction is presented in RUN with no stall.
    assign is_hlt   = (instr_out[15:14] == 2'b11) && (instr_out[7:4] == 4'b1111);
    assign live_run = (state == RUN) && valid_out && !stall;

    // Next-state selection: halt wins over a jump, a jump costs one bubble cycle,
    // otherwise the stage streams sequentially and a stall freezes everything.
    always_comb begin
        state_next  = state;
        fpc_next    = fpc;
        pc_next     = pc_out;
        valid_next  = valid_out;
        halted_next = halted;
        if (!stall) begin
            case (state)
                RUN: begin
                    if (live_run && is_hlt) begin
                        state_next  = HALT;
                        valid_next  = 1'b0;
                        halted_next = 1'b1;
                    end else if (live_run && jflag) begin
                        fpc_next   = jdest;
                        valid_next = 1'b0;
                        state_next = BUBBLE;
                    end else begin
                        fpc_next   = fpc + 12'd1;
                        pc_next    = fpc;
                        valid_next = 1'b1;
                    end
                end
                BUBBLE: begin
                    fpc_next   = fpc + 12'd1;
                    pc_next    = fpc;
                    valid_next = 1'b1;
                    state_next = RUN;
                end
                HALT: begin
                    valid_next  = 1'b0;
                    halted_next = 1'b1;
                end
                default: begin
                    valid_next = 1'b0;
                    state_next = RUN;
                end
            endcase
        end
    end

    // State and fetch registers; reset drops any pending redirect, halt or hold
    // and restarts fetching at address zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            fpc       <= 12'd0;
            pc_out    <= 12'd0;
            valid_out <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_next;
            fpc       <= fpc_next;
            pc_out    <= pc_next;
            valid_out <= valid_next;
            halted    <= halted_next;
        end
    end

endmodule
